// File: rtl/armleocpu_axi_region_router.sv
// ============================================================================
// Module  : armleocpu_axi_region_router
// Brief   : 1-to-N AXI4 address-region router with base translation and DECERR
//           bursts for unmapped addresses. Optional ARMLEOCPU_AXI_ROUTER_STATS_EN
//           adds saturating DECERR acceptance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module armleocpu_axi_region_router #(
    parameter int ADDR_WIDTH = 34,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter int HOST_NUM = 2,
    parameter int REGION_COUNT = 2,
    parameter REGION_HOST_NUM = {1'b1, 1'b0},
    parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_BASE_ADDRS = {34'h1000_0000, 34'h0},
    parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_LENGTHS = {34'h2000, 34'h1000},
    parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_HOST_BASE = {34'h1000_0000, 34'h0}
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         client_axi_awvalid,
    output logic                         client_axi_awready,
    input  logic [ADDR_WIDTH-1:0]        client_axi_awaddr,
    input  logic [7:0]                   client_axi_awlen,
    input  logic [2:0]                   client_axi_awsize,
    input  logic [1:0]                   client_axi_awburst,
    input  logic                         client_axi_awlock,
    input  logic [2:0]                   client_axi_awprot,
    input  logic [ID_WIDTH-1:0]          client_axi_awid,
    input  logic                         client_axi_wvalid,
    output logic                         client_axi_wready,
    input  logic [DATA_WIDTH-1:0]        client_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]      client_axi_wstrb,
    input  logic                         client_axi_wlast,
    output logic                         client_axi_bvalid,
    input  logic                         client_axi_bready,
    output logic [1:0]                   client_axi_bresp,
    output logic [ID_WIDTH-1:0]          client_axi_bid,
    input  logic                         client_axi_arvalid,
    output logic                         client_axi_arready,
    input  logic [ADDR_WIDTH-1:0]        client_axi_araddr,
    input  logic [7:0]                   client_axi_arlen,
    input  logic [2:0]                   client_axi_arsize,
    input  logic [1:0]                   client_axi_arburst,
    input  logic                         client_axi_arlock,
    input  logic [2:0]                   client_axi_arprot,
    input  logic [ID_WIDTH-1:0]          client_axi_arid,
    output logic                         client_axi_rvalid,
    input  logic                         client_axi_rready,
    output logic [1:0]                   client_axi_rresp,
    output logic                         client_axi_rlast,
    output logic [DATA_WIDTH-1:0]        client_axi_rdata,
    output logic [ID_WIDTH-1:0]          client_axi_rid,

    output logic [HOST_NUM-1:0]          host_axi_awvalid,
    input  logic [HOST_NUM-1:0]          host_axi_awready,
    output logic [HOST_NUM*ADDR_WIDTH-1:0] host_axi_awaddr,
    output logic [7:0]                   host_axi_awlen,
    output logic [2:0]                   host_axi_awsize,
    output logic [1:0]                   host_axi_awburst,
    output logic                         host_axi_awlock,
    output logic [2:0]                   host_axi_awprot,
    output logic [ID_WIDTH-1:0]          host_axi_awid,
    output logic [HOST_NUM-1:0]          host_axi_wvalid,
    input  logic [HOST_NUM-1:0]          host_axi_wready,
    output logic [DATA_WIDTH-1:0]        host_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]      host_axi_wstrb,
    output logic                         host_axi_wlast,
    input  logic [HOST_NUM-1:0]          host_axi_bvalid,
    output logic [HOST_NUM-1:0]          host_axi_bready,
    input  logic [HOST_NUM*2-1:0]        host_axi_bresp,
    output logic [HOST_NUM-1:0]          host_axi_arvalid,
    input  logic [HOST_NUM-1:0]          host_axi_arready,
    output logic [HOST_NUM*ADDR_WIDTH-1:0] host_axi_araddr,
    output logic [7:0]                   host_axi_arlen,
    output logic [2:0]                   host_axi_arsize,
    output logic [1:0]                   host_axi_arburst,
    output logic                         host_axi_arlock,
    output logic [2:0]                   host_axi_arprot,
    output logic [ID_WIDTH-1:0]          host_axi_arid,
    input  logic [HOST_NUM-1:0]          host_axi_rvalid,
    output logic [HOST_NUM-1:0]          host_axi_rready,
    input  logic [HOST_NUM-1:0]          host_axi_rlast,
    input  logic [HOST_NUM*2-1:0]        host_axi_rresp,
    input  logic [HOST_NUM*DATA_WIDTH-1:0] host_axi_rdata
`ifdef ARMLEOCPU_AXI_ROUTER_STATS_EN
    ,
    output logic [31:0]                  stat_rd_decerr,
    output logic [31:0]                  stat_wr_decerr
`endif
);

    localparam int HN_W = (HOST_NUM > 1) ? $clog2(HOST_NUM) : 1;

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ACTIVE = 2'd1, RD_DECERR = 2'd2} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ACTIVE = 2'd1, WR_DRAIN = 2'd2, WR_BERR = 2'd3} wr_state_t;

    // Limit computed one bit wider so a region ending at the top of the map still decodes.
    function automatic logic region_hit(input logic [ADDR_WIDTH-1:0] a, input int i);
        logic [ADDR_WIDTH:0] base;
        logic [ADDR_WIDTH:0] lim;
        base = {1'b0, REGION_BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]};
        lim  = base + {1'b0, REGION_LENGTHS[i*ADDR_WIDTH +: ADDR_WIDTH]};
        return ({1'b0, a} >= base) && ({1'b0, a} < lim);
    endfunction

    logic                  w_ar_hit, w_aw_hit;
    logic [HN_W-1:0]       w_ar_port, w_aw_port;
    logic [ADDR_WIDTH-1:0] w_ar_hbase, w_aw_hbase;

    // Descending scan: the lowest matching region is written last and wins.
    always_comb begin
        w_ar_hit = 1'b0; w_ar_port = '0; w_ar_hbase = '0;
        w_aw_hit = 1'b0; w_aw_port = '0; w_aw_hbase = '0;
        for (int i = REGION_COUNT - 1; i >= 0; i--) begin
            if (region_hit(client_axi_araddr, i)) begin
                w_ar_hit   = 1'b1;
                w_ar_port  = REGION_HOST_NUM[i*HN_W +: HN_W];
                w_ar_hbase = REGION_HOST_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (region_hit(client_axi_awaddr, i)) begin
                w_aw_hit   = 1'b1;
                w_aw_port  = REGION_HOST_NUM[i*HN_W +: HN_W];
                w_aw_hbase = REGION_HOST_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic [HN_W-1:0]       r_rd_sel;
    logic [ADDR_WIDTH-1:0] r_rd_hbase;
    logic [ID_WIDTH-1:0]   r_rd_id;
    logic [7:0]            r_rd_cnt;
    logic                  r_ar_done;

    assign host_axi_araddr  = {HOST_NUM{client_axi_araddr - r_rd_hbase}};
    assign host_axi_arlen   = client_axi_arlen;
    assign host_axi_arsize  = client_axi_arsize;
    assign host_axi_arburst = client_axi_arburst;
    assign host_axi_arlock  = client_axi_arlock;
    assign host_axi_arprot  = client_axi_arprot;
    assign host_axi_arid    = client_axi_arid;

    always_comb begin
        w_rd_state_nxt     = r_rd_state;
        client_axi_arready = 1'b0;
        client_axi_rvalid  = 1'b0;
        client_axi_rresp   = 2'b00;
        client_axi_rlast   = 1'b0;
        client_axi_rdata   = '0;
        client_axi_rid     = r_rd_id;
        host_axi_arvalid   = '0;
        host_axi_rready    = '0;
        case (r_rd_state)
            RD_IDLE: begin
                if (client_axi_arvalid && !rst) begin
                    if (w_ar_hit) begin
                        w_rd_state_nxt = RD_ACTIVE;
                    end else begin
                        client_axi_arready = 1'b1;
                        w_rd_state_nxt     = RD_DECERR;
                    end
                end
            end
            RD_ACTIVE: begin
                host_axi_arvalid[r_rd_sel] = client_axi_arvalid && !r_ar_done;
                client_axi_arready         = host_axi_arready[r_rd_sel] && !r_ar_done;
                client_axi_rvalid          = host_axi_rvalid[r_rd_sel];
                client_axi_rresp           = host_axi_rresp[r_rd_sel*2 +: 2];
                client_axi_rlast           = host_axi_rlast[r_rd_sel];
                client_axi_rdata           = host_axi_rdata[r_rd_sel*DATA_WIDTH +: DATA_WIDTH];
                host_axi_rready[r_rd_sel]  = client_axi_rready;
                if (host_axi_rvalid[r_rd_sel] && client_axi_rready && host_axi_rlast[r_rd_sel])
                    w_rd_state_nxt = RD_IDLE;
            end
            RD_DECERR: begin
                client_axi_rvalid = 1'b1;
                client_axi_rresp  = 2'b11;
                client_axi_rlast  = (r_rd_cnt == 8'd0);
                if (client_axi_rready && r_rd_cnt == 8'd0)
                    w_rd_state_nxt = RD_IDLE;
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_sel   <= '0;
            r_rd_hbase <= '0;
            r_rd_id    <= '0;
            r_rd_cnt   <= '0;
            r_ar_done  <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            case (r_rd_state)
                RD_IDLE: begin
                    if (client_axi_arvalid) begin
                        r_rd_sel   <= w_ar_port;
                        r_rd_hbase <= w_ar_hbase;
                        r_rd_id    <= client_axi_arid;
                        r_rd_cnt   <= client_axi_arlen;
                    end
                end
                RD_ACTIVE: begin
                    if (w_rd_state_nxt == RD_IDLE)
                        r_ar_done <= 1'b0;
                    else if (client_axi_arvalid && client_axi_arready)
                        r_ar_done <= 1'b1;
                end
                RD_DECERR: begin
                    if (client_axi_rready)
                        r_rd_cnt <= r_rd_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic [HN_W-1:0]       r_wr_sel;
    logic [ADDR_WIDTH-1:0] r_wr_hbase;
    logic [ID_WIDTH-1:0]   r_wr_id;
    logic                  r_aw_done;

    assign host_axi_awaddr  = {HOST_NUM{client_axi_awaddr - r_wr_hbase}};
    assign host_axi_awlen   = client_axi_awlen;
    assign host_axi_awsize  = client_axi_awsize;
    assign host_axi_awburst = client_axi_awburst;
    assign host_axi_awlock  = client_axi_awlock;
    assign host_axi_awprot  = client_axi_awprot;
    assign host_axi_awid    = client_axi_awid;
    assign host_axi_wdata   = client_axi_wdata;
    assign host_axi_wstrb   = client_axi_wstrb;
    assign host_axi_wlast   = client_axi_wlast;

    always_comb begin
        w_wr_state_nxt     = r_wr_state;
        client_axi_awready = 1'b0;
        client_axi_wready  = 1'b0;
        client_axi_bvalid  = 1'b0;
        client_axi_bresp   = 2'b00;
        client_axi_bid     = r_wr_id;
        host_axi_awvalid   = '0;
        host_axi_wvalid    = '0;
        host_axi_bready    = '0;
        case (r_wr_state)
            WR_IDLE: begin
                if (client_axi_awvalid && !rst) begin
                    if (w_aw_hit) begin
                        w_wr_state_nxt = WR_ACTIVE;
                    end else begin
                        client_axi_awready = 1'b1;
                        w_wr_state_nxt     = WR_DRAIN;
                    end
                end
            end
            WR_ACTIVE: begin
                host_axi_awvalid[r_wr_sel] = client_axi_awvalid && !r_aw_done;
                client_axi_awready         = host_axi_awready[r_wr_sel] && !r_aw_done;
                host_axi_wvalid[r_wr_sel]  = client_axi_wvalid;
                client_axi_wready          = host_axi_wready[r_wr_sel];
                client_axi_bvalid          = host_axi_bvalid[r_wr_sel];
                client_axi_bresp           = host_axi_bresp[r_wr_sel*2 +: 2];
                host_axi_bready[r_wr_sel]  = client_axi_bready;
                if (host_axi_bvalid[r_wr_sel] && client_axi_bready)
                    w_wr_state_nxt = WR_IDLE;
            end
            WR_DRAIN: begin
                client_axi_wready = 1'b1;
                if (client_axi_wvalid && client_axi_wlast)
                    w_wr_state_nxt = WR_BERR;
            end
            WR_BERR: begin
                client_axi_bvalid = 1'b1;
                client_axi_bresp  = 2'b11;
                if (client_axi_bready)
                    w_wr_state_nxt = WR_IDLE;
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_wr_sel   <= '0;
            r_wr_hbase <= '0;
            r_wr_id    <= '0;
            r_aw_done  <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (r_wr_state == WR_IDLE && client_axi_awvalid) begin
                r_wr_sel   <= w_aw_port;
                r_wr_hbase <= w_aw_hbase;
                r_wr_id    <= client_axi_awid;
            end
            if (r_wr_state == WR_ACTIVE) begin
                if (w_wr_state_nxt == WR_IDLE)
                    r_aw_done <= 1'b0;
                else if (client_axi_awvalid && client_axi_awready)
                    r_aw_done <= 1'b1;
            end
        end
    end

`ifdef ARMLEOCPU_AXI_ROUTER_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr;

    // In IDLE the address channel is only ever accepted for an unmapped target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (r_rd_state == RD_IDLE && client_axi_arvalid && client_axi_arready && r_stat_rd != 32'hFFFF_FFFF)
                r_stat_rd <= r_stat_rd + 32'd1;
            if (r_wr_state == WR_IDLE && client_axi_awvalid && client_axi_awready && r_stat_wr != 32'hFFFF_FFFF)
                r_stat_wr <= r_stat_wr + 32'd1;
        end
    end

    assign stat_rd_decerr = r_stat_rd;
    assign stat_wr_decerr = r_stat_wr;
`endif

endmodule

`default_nettype wire
